psum_acc_buf: RTL and testbench
===============================

Name: psum_acc_buf

Overview:
- Downstream neighbour of the PE-array controller FSM.
- Consumes delayed partial-sum beats from the PE array, qualified by p_valid and last_channel, and accumulates them across input-channel groups in a per-position register buffer.
- On the last channel group it applies ReLU, shift and saturation.
- Pushes the finished pixels into an output FIFO that drains to the OFM writer over a valid/ready handshake.

Parameters:
- LANES, 8, output channels per beat (one psum word per lane).
- PSUM_W, 24, signed partial-sum width per lane.
- OUT_W, 8, unsigned quantised output width per lane.
- TILE_LEN, 16, beats per channel group (one row tile); buffer depth.
- FIFO_DEPTH, 8, output FIFO entries; power of 2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start_conv  in  1  one-cycle pulse that clears all state for a new layer.
- cfg_shift  in  5  right-shift amount for requantisation; sampled on start_conv.
- p_valid  in  1  psum beat valid (from PE FSM delay line).
- last_channel  in  1  beat belongs to the final input-channel group.
- psum_in  in  LANES*PSUM_W  signed psums; lane i = bits [i*PSUM_W +: PSUM_W].
- end_conv  in  1  pulse: no further beats for this layer.
- out_valid  out  1  FIFO head valid.
- out_data  out  LANES*OUT_W  quantised pixel vector.
- out_ready  in  1  consumer accepts head.
- ovf_err  out  1  sticky: beat lost because FIFO full.
- done  out  1  one-cycle pulse: layer fully drained.

Behaviour:
- Reset values: out_valid=0, out_data=0, ovf_err=0, done=0. Internally addr=0, first_pass=1, shift=0, FIFO empty, end_pending=0.
- start_conv (synchronous): performs the same clears as reset except buffer contents (don't-care), and latches cfg_shift. If it coincides with p_valid, start_conv wins and the beat is dropped.
- Address: addr (log2 TILE_LEN bits) increments on each p_valid beat and wraps TILE_LEN-1 -> 0.
- first_pass update on wrap: first_pass <= last_channel of the wrapping beat. A finished group makes the next group a first pass; otherwise the next group accumulates.
- Stage 1, at the p_valid cycle t:
  - base = first_pass ? 0 : buf[addr].
  - sum_i = base_i + psum_in_i, 2's-complement wrap at PSUM_W (no saturation).
  - If last_channel=0: buf[addr] <= sum at edge t.
  - If last_channel=1: buf[addr] not written; sum is registered into the stage-2 register s2_data, with s2_v=1 at t+1.
- Stage 2, at t+1, per lane:
  - r = (sum_i < 0) ? 0 : sum_i.
  - q = r >>> shift.
  - out lane = (q > 2^OUT_W-1) ? 2^OUT_W-1 : q.
  - Push into FIFO at edge t+1. out_valid is visible at t+2 when the FIFO was empty (latency 2 from beat to out_valid).
- FIFO:
  - Show-ahead; out_data = head.
  - Pop when out_valid & out_ready.
  - Push and pop in the same cycle are both honoured, including when full.
  - Push while full with no pop: drop the entry, ovf_err <= 1 (sticky until reset/start_conv), other entries unaffected.
  - Pop while empty is ignored.
- Throughput: one beat per cycle. Back-to-back p_valid to the same addr cannot occur within 2 cycles (TILE_LEN >= 2), so no read-after-write bypass is needed.
- Done logic:
  - end_conv sets end_pending.
  - done pulses for one cycle in the first cycle where end_pending=1, s2_v=0 and the FIFO is empty; end_pending then clears.
  - end_conv while already drained gives done at the next cycle.
- p_valid with last_channel=1 on the very first group (single channel group) produces outputs directly from psum_in.
- p_valid=0 cycles hold all state; last_channel is ignored when p_valid=0.
- Asynchronous reset mid-layer discards buffer, pipeline and FIFO contents; outputs return to their reset values immediately.

Decomposition:
- Shared package (acc_pkg): LANES, PSUM_W, OUT_W, TILE_LEN, FIFO_DEPTH defaults; the ADDR_W=$clog2(TILE_LEN) constant; a relu_shift_sat function (PSUM_W in, OUT_W out).
- One natural sub-module: sync_fifo (parameterised width/depth, show-ahead, full/empty, simultaneous push/pop). It is instantiated once for the output queue.

Test Plan:
- Single group:
  - Stimulus: start_conv with shift=0; 16 beats last_channel=1, lane0 psum = 5,-3,300,...; out_ready=1.
  - Response: out lane0 = 5,0,255,...; out_valid first seen 2 cycles after first beat; 16 outputs.
- Three groups:
  - Stimulus: shift=2; groups with lane0 psum 10, 20, 14 at addr k; last_channel=1 on the third group only.
  - Response: out lane0 = (44>>2)=11 for every addr; no outputs during groups 1-2.
- Layer reuse:
  - Stimulus: after a completed tile, a new tile's first group with psum=7 (non-last) then psum=1 (last).
  - Response: output 8, proving first_pass re-armed and the old buffer ignored.
- Backpressure:
  - Stimulus: out_ready=0; 16 last beats with FIFO_DEPTH=8.
  - Response: 8 entries held, ovf_err=1 after the 9th push; then out_ready=1 drains exactly 8 entries in order.
- Full push/pop:
  - Stimulus: FIFO full; push and pop in the same cycle.
  - Response: count stays 8, ovf_err stays 0.
- Done/reset:
  - Stimulus 1: end_conv 1 cycle after the last beat.
  - Response 1: done pulses exactly once after the final pop.
  - Stimulus 2: rst_n low mid-tile.
  - Response 2: out_valid=0 at once; no stale output after release.

Source files
------------

// File: rtl/psum_acc_buf_pkg.sv
// Shared sizing constants and the per-lane requantisation helper
// for the partial-sum accumulation buffer.
package acc_pkg;

    localparam int LANES      = 8;
    localparam int PSUM_W     = 24;
    localparam int OUT_W      = 8;
    localparam int TILE_LEN   = 16;
    localparam int FIFO_DEPTH = 8;
    localparam int ADDR_W     = $clog2(TILE_LEN);

    // ReLU, arithmetic right shift, then clamp to the unsigned output range.
    function automatic logic [OUT_W-1:0] relu_shift_sat(
        input logic signed [PSUM_W-1:0] v,
        input logic        [4:0]        sh
    );
        logic [PSUM_W-1:0] r;
        logic [PSUM_W-1:0] q;
        r = v[PSUM_W-1] ? '0 : v;
        q = r >> sh;
        if (q > PSUM_W'((1 << OUT_W) - 1))
            return '1;
        return q[OUT_W-1:0];
    endfunction

endpackage

// File: rtl/psum_acc_buf_sync_fifo.sv
// Show-ahead synchronous FIFO with simultaneous push/pop honoured even when full.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop && !empty;
    // A pop frees the slot the push lands in, so full does not block it.
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/psum_acc_buf.sv
// Accumulates partial-sum beats across input-channel groups, requantises the
// final group and queues finished pixel vectors for the OFM writer.
module psum_acc_buf
    import acc_pkg::*;
#(
    parameter int LANES      = acc_pkg::LANES,
    parameter int PSUM_W     = acc_pkg::PSUM_W,
    parameter int OUT_W      = acc_pkg::OUT_W,
    parameter int TILE_LEN   = acc_pkg::TILE_LEN,
    parameter int FIFO_DEPTH = acc_pkg::FIFO_DEPTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start_conv,
    input  logic [4:0]              cfg_shift,
    input  logic                    p_valid,
    input  logic                    last_channel,
    input  logic [LANES*PSUM_W-1:0] psum_in,
    input  logic                    end_conv,
    output logic                    out_valid,
    output logic [LANES*OUT_W-1:0]  out_data,
    input  logic                    out_ready,
    output logic                    ovf_err,
    output logic                    done
);

    localparam int AW     = $clog2(TILE_LEN);
    localparam int VEC_W  = LANES * PSUM_W;
    localparam int OVEC_W = LANES * OUT_W;

    logic [VEC_W-1:0]  acc_mem [TILE_LEN];
    logic [AW-1:0]     addr;
    logic              first_pass;
    logic [4:0]        shift;
    logic [VEC_W-1:0]  base;
    logic [VEC_W-1:0]  sum;
    logic              beat;
    logic              s2_v;
    logic [VEC_W-1:0]  s2_data;
    logic [OVEC_W-1:0] q_data;
    logic              end_pending;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;

    // start_conv takes priority over a coincident beat, which is dropped.
    assign beat = p_valid && !start_conv;
    assign base = first_pass ? '0 : acc_mem[addr];

    always_comb begin
        sum = '0;
        for (int unsigned i = 0; i < LANES; i++)
            sum[i*PSUM_W +: PSUM_W] = base[i*PSUM_W +: PSUM_W] + psum_in[i*PSUM_W +: PSUM_W];
    end

    always_ff @(posedge clk) begin
        if (beat && !last_channel)
            acc_mem[addr] <= sum;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr        <= '0;
            first_pass  <= 1'b1;
            shift       <= '0;
            s2_v        <= 1'b0;
            s2_data     <= '0;
            end_pending <= 1'b0;
            ovf_err     <= 1'b0;
        end else if (start_conv) begin
            addr        <= '0;
            first_pass  <= 1'b1;
            shift       <= cfg_shift;
            s2_v        <= 1'b0;
            end_pending <= 1'b0;
            ovf_err     <= 1'b0;
        end else begin
            s2_v <= p_valid && last_channel;
            if (p_valid && last_channel)
                s2_data <= sum;
            if (p_valid) begin
                if (addr == AW'(TILE_LEN - 1)) begin
                    addr       <= '0;
                    first_pass <= last_channel;
                end else begin
                    addr <= addr + 1'b1;
                end
            end
            if (end_conv)
                end_pending <= 1'b1;
            else if (done)
                end_pending <= 1'b0;
            if (s2_v && fifo_full && !fifo_pop)
                ovf_err <= 1'b1;
        end
    end

    always_comb begin
        q_data = '0;
        for (int unsigned i = 0; i < LANES; i++)
            q_data[i*OUT_W +: OUT_W] = relu_shift_sat(s2_data[i*PSUM_W +: PSUM_W], shift);
    end

    assign fifo_pop  = out_ready && !fifo_empty;
    assign out_valid = !fifo_empty;
    assign done      = end_pending && !s2_v && fifo_empty;

    sync_fifo #(
        .WIDTH (OVEC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_out_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (start_conv),
        .push      (s2_v),
        .push_data (q_data),
        .pop       (out_ready),
        .head      (out_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_psum_acc_buf.sv
// Self-checking bench for psum_acc_buf: random beats against a tile-level
// accumulate/requantise model with an ordered output scoreboard.
module tb_psum_acc_buf;
    import acc_pkg::*;

    localparam int VW = LANES * PSUM_W;
    localparam int OW = LANES * OUT_W;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start_conv;
    logic [4:0]    cfg_shift;
    logic          p_valid;
    logic          last_channel;
    logic [VW-1:0] psum_in;
    logic          end_conv;
    logic          out_valid;
    logic [OW-1:0] out_data;
    logic          out_ready;
    logic          ovf_err;
    logic          done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [OW-1:0] got[$];
    logic [OW-1:0] exp_q[$];
    int acc[TILE_LEN][LANES];
    int m_addr;
    bit m_first;
    int m_shift;

    always #5 clk = ~clk;

    psum_acc_buf #(
        .LANES      (LANES),
        .PSUM_W     (PSUM_W),
        .OUT_W      (OUT_W),
        .TILE_LEN   (TILE_LEN),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_conv   (start_conv),
        .cfg_shift    (cfg_shift),
        .p_valid      (p_valid),
        .last_channel (last_channel),
        .psum_in      (psum_in),
        .end_conv     (end_conv),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_ready    (out_ready),
        .ovf_err      (ovf_err),
        .done         (done)
    );

    always @(negedge clk)
        if (rst_n && out_valid && out_ready)
            got.push_back(out_data);

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int wrap_psum(int x);
        return (x <<< (32 - PSUM_W)) >>> (32 - PSUM_W);
    endfunction

    function automatic int quant(int s, int sh);
        int r;
        r = (s < 0) ? 0 : s;
        r = r >> sh;
        return (r > (1 << OUT_W) - 1) ? (1 << OUT_W) - 1 : r;
    endfunction

    function automatic void model_reset(int sh);
        m_addr  = 0;
        m_first = 1'b1;
        m_shift = sh;
        got.delete();
        exp_q.delete();
    endfunction

    function automatic void model_beat(bit lc, logic [VW-1:0] d);
        logic [OW-1:0] e;
        int s;
        e = '0;
        for (int i = 0; i < LANES; i++) begin
            s = wrap_psum((m_first ? 0 : acc[m_addr][i]) + int'($signed(d[i*PSUM_W +: PSUM_W])));
            if (lc) e[i*OUT_W +: OUT_W] = OUT_W'(quant(s, m_shift));
            else    acc[m_addr][i] = s;
        end
        if (lc) exp_q.push_back(e);
        m_addr++;
        if (m_addr == TILE_LEN) begin
            m_addr  = 0;
            m_first = lc;
        end
    endfunction

    function automatic logic [VW-1:0] rand_vec(bit full_range);
        logic [VW-1:0] v;
        for (int i = 0; i < LANES; i++)
            v[i*PSUM_W +: PSUM_W] = full_range ? PSUM_W'($urandom)
                                               : PSUM_W'(int'($urandom_range(0, 1200)) - 600);
        return v;
    endfunction

    function automatic logic [VW-1:0] fill_vec(int x);
        logic [VW-1:0] v;
        for (int i = 0; i < LANES; i++)
            v[i*PSUM_W +: PSUM_W] = PSUM_W'(x);
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(bit pv, bit lc, logic [VW-1:0] d);
        p_valid      = pv;
        last_channel = lc;
        psum_in      = d;
        if (pv) model_beat(lc, d);
    endtask

    task automatic idle(int n);
        drive(1'b0, 1'b0, '0);
        repeat (n) tick();
    endtask

    task automatic start(int sh);
        start_conv = 1'b1;
        cfg_shift  = 5'(sh);
        tick();
        start_conv = 1'b0;
        model_reset(sh);
    endtask

    task automatic wait_got(int n, int budget);
        int c;
        c = 0;
        while (got.size() < n && c < budget) begin
            tick();
            c++;
        end
    endtask

    task automatic group(bit lc, bit full_range);
        for (int k = 0; k < TILE_LEN; k++) begin
            drive(1'b1, lc, rand_vec(full_range));
            tick();
        end
        drive(1'b0, 1'b0, '0);
    endtask

    task automatic test_reset();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
        n_checks++; if (ovf_err !== 1'b0) begin n_fail++; $display("FAIL reset_ovf_err got=%b exp=0", ovf_err); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
    endtask

    task automatic test_single_group();
        int l0_in[3]  = '{5, -3, 300};
        int l0_exp[3] = '{5, 0, 255};
        logic [VW-1:0] d;
        start(0);
        out_ready = 1'b1;
        for (int k = 0; k < TILE_LEN; k++) begin
            d = rand_vec(1'b0);
            if (k < 3) d[PSUM_W-1:0] = PSUM_W'(l0_in[k]);
            drive(1'b1, 1'b1, d);
            @(negedge clk);
            n_checks++;
            if (out_valid !== (k >= 2)) begin
                n_fail++; $display("FAIL single_latency beat=%0d got=%b exp=%b", k, out_valid, (k >= 2));
            end
            tick();
        end
        drive(1'b0, 1'b0, '0);
        wait_got(TILE_LEN, 20);
        n_checks++;
        if (got.size() != TILE_LEN) begin n_fail++; $display("FAIL single_count got=%0d exp=%0d", got.size(), TILE_LEN); end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (i >= got.size() || got[i][OUT_W-1:0] !== OUT_W'(l0_exp[i])) begin
                n_fail++; $display("FAIL single_lane0 idx=%0d got=%0d exp=%0d", i, (i < got.size()) ? got[i][OUT_W-1:0] : 0, l0_exp[i]);
            end
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (i >= got.size() || got[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL single_data idx=%0d got=%h exp=%h", i, (i < got.size()) ? got[i] : '0, exp_q[i]);
            end
        end
    endtask

    task automatic test_three_groups();
        int l0[3] = '{10, 20, 14};
        logic [VW-1:0] d;
        start(2);
        out_ready = 1'b1;
        for (int g = 0; g < 3; g++) begin
            for (int k = 0; k < TILE_LEN; k++) begin
                d = rand_vec(1'b1);
                d[PSUM_W-1:0] = PSUM_W'(l0[g]);
                drive(1'b1, g == 2, d);
                tick();
            end
            if (g == 1) begin
                idle(3);
                n_checks++; if (got.size() != 0) begin n_fail++; $display("FAIL three_early_out got=%0d exp=0", got.size()); end
                n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL three_early_valid got=%b exp=0", out_valid); end
            end
        end
        drive(1'b0, 1'b0, '0);
        wait_got(TILE_LEN, 20);
        n_checks++;
        if (got.size() != TILE_LEN) begin n_fail++; $display("FAIL three_count got=%0d exp=%0d", got.size(), TILE_LEN); end
        for (int i = 0; i < got.size(); i++) begin
            n_checks++;
            if (got[i][OUT_W-1:0] !== OUT_W'(11)) begin n_fail++; $display("FAIL three_lane0 idx=%0d got=%0d exp=11", i, got[i][OUT_W-1:0]); end
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (i >= got.size() || got[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL three_data idx=%0d got=%h exp=%h", i, (i < got.size()) ? got[i] : '0, exp_q[i]);
            end
        end
    endtask

    task automatic test_layer_reuse();
        start(0);
        out_ready = 1'b1;
        for (int k = 0; k < TILE_LEN; k++) begin drive(1'b1, 1'b1, fill_vec(1000)); tick(); end
        idle(1);
        wait_got(TILE_LEN, 20);
        got.delete();
        exp_q.delete();
        for (int k = 0; k < TILE_LEN; k++) begin drive(1'b1, 1'b0, fill_vec(7)); tick(); end
        for (int k = 0; k < TILE_LEN; k++) begin drive(1'b1, 1'b1, fill_vec(1)); tick(); end
        idle(1);
        wait_got(TILE_LEN, 20);
        n_checks++;
        if (got.size() != TILE_LEN) begin n_fail++; $display("FAIL reuse_count got=%0d exp=%0d", got.size(), TILE_LEN); end
        for (int i = 0; i < got.size(); i++) begin
            n_checks++;
            if (got[i] !== {LANES{OUT_W'(8)}} || (i < exp_q.size() && got[i] !== exp_q[i])) begin
                n_fail++; $display("FAIL reuse_data idx=%0d got=%h exp=%h", i, got[i], {LANES{OUT_W'(8)}});
            end
        end
    endtask

    task automatic test_backpressure();
        start(0);
        out_ready = 1'b0;
        for (int k = 0; k < TILE_LEN; k++) begin
            drive(1'b1, 1'b1, rand_vec(1'b0));
            @(negedge clk);
            n_checks++;
            if (ovf_err !== (k >= FIFO_DEPTH + 2)) begin
                n_fail++; $display("FAIL bp_ovf beat=%0d got=%b exp=%b", k, ovf_err, (k >= FIFO_DEPTH + 2));
            end
            tick();
        end
        idle(3);
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_held_valid got=%b exp=1", out_valid); end
        n_checks++; if (ovf_err !== 1'b1) begin n_fail++; $display("FAIL bp_ovf_sticky got=%b exp=1", ovf_err); end
        while (exp_q.size() > FIFO_DEPTH) void'(exp_q.pop_back());
        out_ready = 1'b1;
        wait_got(FIFO_DEPTH, 20);
        idle(3);
        n_checks++;
        if (got.size() != FIFO_DEPTH) begin n_fail++; $display("FAIL bp_drain_count got=%0d exp=%0d", got.size(), FIFO_DEPTH); end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (i >= got.size() || got[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL bp_data idx=%0d got=%h exp=%h", i, (i < got.size()) ? got[i] : '0, exp_q[i]);
            end
        end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty got=%b exp=0", out_valid); end
    endtask

    task automatic test_full_push_pop();
        start(0);
        out_ready = 1'b0;
        for (int k = 0; k < FIFO_DEPTH; k++) begin drive(1'b1, 1'b1, rand_vec(1'b0)); tick(); end
        idle(3);
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL fpp_full_valid got=%b exp=1", out_valid); end
        // Pushes of beats 0..3 land in cycles 1..4, each paired with a pop.
        for (int c = 0; c < 5; c++) begin
            if (c < 4) drive(1'b1, 1'b1, rand_vec(1'b0));
            else       drive(1'b0, 1'b0, '0);
            out_ready = (c >= 1 && c <= 4);
            tick();
        end
        out_ready = 1'b0;
        idle(2);
        n_checks++; if (ovf_err !== 1'b0) begin n_fail++; $display("FAIL fpp_ovf got=%b exp=0", ovf_err); end
        n_checks++; if (got.size() != 4) begin n_fail++; $display("FAIL fpp_popped got=%0d exp=4", got.size()); end
        out_ready = 1'b1;
        wait_got(FIFO_DEPTH + 4, 20);
        idle(2);
        n_checks++;
        if (got.size() != FIFO_DEPTH + 4) begin n_fail++; $display("FAIL fpp_count got=%0d exp=%0d", got.size(), FIFO_DEPTH + 4); end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (i >= got.size() || got[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL fpp_data idx=%0d got=%h exp=%h", i, (i < got.size()) ? got[i] : '0, exp_q[i]);
            end
        end
    endtask

    task automatic test_start_collision();
        out_ready    = 1'b1;
        start_conv   = 1'b1;
        cfg_shift    = 5'd1;
        p_valid      = 1'b1;
        last_channel = 1'b1;
        psum_in      = fill_vec(500);
        tick();
        start_conv = 1'b0;
        model_reset(1);
        group(1'b1, 1'b0);
        wait_got(TILE_LEN, 20);
        idle(3);
        n_checks++;
        if (got.size() != TILE_LEN) begin n_fail++; $display("FAIL collide_count got=%0d exp=%0d", got.size(), TILE_LEN); end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (i >= got.size() || got[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL collide_data idx=%0d got=%h exp=%h", i, (i < got.size()) ? got[i] : '0, exp_q[i]);
            end
        end
    endtask

    task automatic test_done();
        int dcount, dcycle, dgot;
        dcount = 0; dcycle = -1; dgot = -1;
        start(0);
        out_ready = 1'b1;
        group(1'b1, 1'b0);
        end_conv = 1'b1;
        tick();
        end_conv = 1'b0;
        for (int c = TILE_LEN + 1; c < TILE_LEN + 21; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                dcount++;
                dcycle = c;
                dgot   = got.size();
            end
            tick();
        end
        n_checks++; if (dcount != 1) begin n_fail++; $display("FAIL done_pulses got=%0d exp=1", dcount); end
        n_checks++; if (dcycle != TILE_LEN + 2) begin n_fail++; $display("FAIL done_cycle got=%0d exp=%0d", dcycle, TILE_LEN + 2); end
        n_checks++; if (dgot != TILE_LEN) begin n_fail++; $display("FAIL done_after_pop got=%0d exp=%0d", dgot, TILE_LEN); end
        end_conv = 1'b1;
        @(negedge clk);
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL done_drained_early got=%b exp=0", done); end
        tick();
        end_conv = 1'b0;
        @(negedge clk);
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL done_drained got=%b exp=1", done); end
        tick();
        @(negedge clk);
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL done_single got=%b exp=0", done); end
        tick();
    endtask

    task automatic test_reset_mid();
        start(0);
        out_ready = 1'b0;
        group(1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin drive(1'b1, 1'b1, rand_vec(1'b0)); tick(); end
        idle(3);
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rst_pre_valid got=%b exp=1", out_valid); end
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_async_valid got=%b exp=0", out_valid); end
        n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL rst_async_data got=%h exp=0", out_data); end
        n_checks++; if (ovf_err !== 1'b0) begin n_fail++; $display("FAIL rst_async_ovf got=%b exp=0", ovf_err); end
        tick();
        rst_n = 1'b1;
        model_reset(0);
        out_ready = 1'b1;
        idle(5);
        n_checks++; if (got.size() != 0) begin n_fail++; $display("FAIL rst_stale got=%0d exp=0", got.size()); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_post_valid got=%b exp=0", out_valid); end
        group(1'b1, 1'b0);
        wait_got(TILE_LEN, 20);
        idle(2);
        n_checks++;
        if (got.size() != TILE_LEN) begin n_fail++; $display("FAIL rst_count got=%0d exp=%0d", got.size(), TILE_LEN); end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (i >= got.size() || got[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL rst_data idx=%0d got=%h exp=%h", i, (i < got.size()) ? got[i] : '0, exp_q[i]);
            end
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        start_conv   = 1'b0;
        cfg_shift    = '0;
        p_valid      = 1'b0;
        last_channel = 1'b0;
        psum_in      = '0;
        end_conv     = 1'b0;
        out_ready    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        tick();
        test_single_group();
        test_three_groups();
        test_layer_reuse();
        test_backpressure();
        test_full_push_pop();
        test_start_collision();
        test_done();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
